// File: rtl/sevenseg_pkg.sv
`default_nettype none
// ============================================================================
// sevenseg_pkg : shared types and constants for the seven-segment scan slice
// Revision     : 1.0
// ============================================================================
package sevenseg_pkg;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    typedef logic [3:0] bcd_t;

    localparam int PWM_WIDTH = 4;

endpackage
`default_nettype wire

// File: rtl/sevenseg_pwm.sv
`default_nettype none
// ============================================================================
// sevenseg_pwm : brightness compare producing the dim mask during SHOW
// Built only when SEVENSEG_PWM_EN is defined.
// Revision     : 1.0
// ============================================================================
`ifdef SEVENSEG_PWM_EN
module sevenseg_pwm
    import sevenseg_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [PWM_WIDTH-1:0] bright_i,
    output logic                 dim
);

    logic [PWM_WIDTH-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [PWM_WIDTH-1:0] bright_q, bright_d;

    // load arrives on the edge into SHOW, so the first lit cycle sees a cleared count
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + 4'd1;
        bright_d  = bright_q;
        if (load) begin
            pwm_cnt_d = '0;
            bright_d  = bright_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pwm_cnt_q <= '0;
            bright_q  <= '0;
        end else begin
            pwm_cnt_q <= pwm_cnt_d;
            bright_q  <= bright_d;
        end
    end

    assign dim = (pwm_cnt_q >= bright_q);

endmodule
`endif
`default_nettype wire

// File: rtl/sevenseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// sevenseg_scan_ctrl : two-digit scan FSM with blanking, PWM dim, and
// frame-synchronous BCD double buffer. Optional macro: SEVENSEG_PWM_EN.
// Revision          : 1.0
// ============================================================================
module sevenseg_scan_ctrl
    import sevenseg_pkg::*;
#(
    parameter int DIV_WIDTH    = 16,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DIV_WIDTH-1:0] div_i,
    input  logic [PWM_WIDTH-1:0] bright_i,
    input  logic                 upd_valid,
    output logic                 upd_ready,
    input  logic [3:0]           upd_tens,
    input  logic [3:0]           upd_units,
    output logic                 digit_en,
    output logic                 blank,
    output logic [3:0]           tens_bcd,
    output logic [3:0]           units_bcd,
    output logic                 frame_done
);

    localparam logic [7:0] BLANK_LAST = 8'(BLANK_CYCLES - 1);

    scan_state_t          state_q, state_d;
    logic [7:0]           blank_cnt_q, blank_cnt_d;
    logic [DIV_WIDTH-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [DIV_WIDTH-1:0] div_lat_q, div_lat_d;
    logic                 phase_q, phase_d;
    logic                 pending_q, pending_d;
    bcd_t                 shadow_tens_q, shadow_tens_d;
    bcd_t                 shadow_units_q, shadow_units_d;
    bcd_t                 tens_q, tens_d;
    bcd_t                 units_q, units_d;

    logic show_entry;
    logic show_exit;
    logic xfer;
    logic dim;

    // reset-held state already looks like a fresh BLANK; keep the strobe quiet until release
    assign digit_en   = rst && (state_q == BLANK) && (blank_cnt_q == 8'd0);
    assign frame_done = digit_en && !phase_q;
    assign show_entry = (state_q == BLANK) && (blank_cnt_q == BLANK_LAST);
    assign show_exit  = (state_q == SHOW) && (dwell_cnt_q == div_lat_q);
    assign upd_ready  = !pending_q;
    assign xfer       = upd_valid && upd_ready;
    assign blank      = (state_q == BLANK) || dim;
    assign tens_bcd   = tens_q;
    assign units_bcd  = units_q;

`ifdef SEVENSEG_PWM_EN
    logic pwm_dim;

    sevenseg_pwm u_pwm (
        .clk      (clk),
        .rst      (rst),
        .load     (show_entry),
        .bright_i (bright_i),
        .dim      (pwm_dim)
    );

    assign dim = (state_q == SHOW) && pwm_dim;
`else
    logic unused_bright;
    assign unused_bright = ^bright_i;
    assign dim           = 1'b0;
`endif

    always_comb begin
        state_d        = state_q;
        blank_cnt_d    = blank_cnt_q;
        dwell_cnt_d    = dwell_cnt_q;
        div_lat_d      = div_lat_q;
        phase_d        = phase_q;
        pending_d      = pending_q;
        shadow_tens_d  = shadow_tens_q;
        shadow_units_d = shadow_units_q;
        tens_d         = tens_q;
        units_d        = units_q;

        case (state_q)
            BLANK: begin
                blank_cnt_d = blank_cnt_q + 8'd1;
                if (show_entry) begin
                    state_d     = SHOW;
                    blank_cnt_d = 8'd0;
                    dwell_cnt_d = '0;
                    div_lat_d   = div_i;
                end
            end
            SHOW: begin
                dwell_cnt_d = dwell_cnt_q + DIV_WIDTH'(1);
                if (show_exit) begin
                    state_d = BLANK;
                end
            end
            default: state_d = BLANK;
        endcase

        if (digit_en) begin
            phase_d = !phase_q;
        end

        // commit and capture can never coincide: one needs pending, the other needs it clear
        if (frame_done && pending_q) begin
            tens_d    = shadow_tens_q;
            units_d   = shadow_units_q;
            pending_d = 1'b0;
        end
        if (xfer) begin
            shadow_tens_d  = upd_tens;
            shadow_units_d = upd_units;
            pending_d      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= BLANK;
            blank_cnt_q    <= 8'd0;
            dwell_cnt_q    <= '0;
            div_lat_q      <= '0;
            phase_q        <= 1'b1;
            pending_q      <= 1'b0;
            shadow_tens_q  <= '0;
            shadow_units_q <= '0;
            tens_q         <= '0;
            units_q        <= '0;
        end else begin
            state_q        <= state_d;
            blank_cnt_q    <= blank_cnt_d;
            dwell_cnt_q    <= dwell_cnt_d;
            div_lat_q      <= div_lat_d;
            phase_q        <= phase_d;
            pending_q      <= pending_d;
            shadow_tens_q  <= shadow_tens_d;
            shadow_units_q <= shadow_units_d;
            tens_q         <= tens_d;
            units_q        <= units_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sevenseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// tb_sevenseg_scan_ctrl : scoreboard bench with a slot-timeline reference model
// Revision              : 1.0
// ============================================================================
module tb_sevenseg_scan_ctrl;

    localparam int BLANK_CYC = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] div_i;
    logic [3:0]  bright_i;
    logic        upd_valid;
    logic        upd_ready;
    logic [3:0]  upd_tens;
    logic [3:0]  upd_units;
    logic        digit_en;
    logic        blank;
    logic [3:0]  tens_bcd;
    logic [3:0]  units_bcd;
    logic        frame_done;

    sevenseg_scan_ctrl #(
        .DIV_WIDTH    (16),
        .BLANK_CYCLES (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .div_i      (div_i),
        .bright_i   (bright_i),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_tens   (upd_tens),
        .upd_units  (upd_units),
        .digit_en   (digit_en),
        .blank      (blank),
        .tens_bcd   (tens_bcd),
        .units_bcd  (units_bcd),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       de;
        logic       fd;
        logic       bl;
        logic [3:0] t;
        logic [3:0] u;
        logic       rdy;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    // Reference model: position inside the current digit slot plus display/buffer contents
    int         m_pos     = 0;
    int         m_div     = 0;
    int         m_bright  = 0;
    logic       m_units   = 1'b1;
    logic       m_pending = 1'b0;
    logic [3:0] m_sh_t    = 4'd0;
    logic [3:0] m_sh_u    = 4'd0;
    logic [3:0] m_t       = 4'd0;
    logic [3:0] m_u       = 4'd0;

    task automatic step(input logic r, input logic v, input logic [3:0] ut,
                        input logic [3:0] uu, input int dv, input int br);
        exp_t e;
        logic de;
        logic fd;
        logic acc;
        int   s;
        @(posedge clk);
        #1;
        cyc++;
        rst       = r;
        upd_valid = v;
        upd_tens  = ut;
        upd_units = uu;
        div_i     = 16'(dv);
        bright_i  = 4'(br);

        de    = r && (m_pos == 0);
        fd    = de && !m_units;
        e.de  = de;
        e.fd  = fd;
        if (m_pos < BLANK_CYC) begin
            e.bl = 1'b1;
        end else begin
            s = m_pos - BLANK_CYC;
`ifdef SEVENSEG_PWM_EN
            e.bl = ((s % 16) >= m_bright);
`else
            e.bl = (s < 0);
`endif
        end
        e.t   = m_t;
        e.u   = m_u;
        e.rdy = !m_pending;
        exp_q.push_back(e);

        if (!r) begin
            m_pos     = 0;
            m_units   = 1'b1;
            m_pending = 1'b0;
            m_t       = 4'd0;
            m_u       = 4'd0;
        end else begin
            acc = v && !m_pending;
            if (de) m_units = !m_units;
            if (fd && m_pending) begin
                m_t       = m_sh_t;
                m_u       = m_sh_u;
                m_pending = 1'b0;
            end
            if (acc) begin
                m_sh_t    = ut;
                m_sh_u    = uu;
                m_pending = 1'b1;
            end
            if (m_pos == BLANK_CYC - 1) begin
                m_div    = dv;
                m_bright = br;
            end
            if (m_pos == BLANK_CYC + m_div) m_pos = 0;
            else                            m_pos++;
        end
    endtask

    exp_t mon_e;
    exp_t mon_g;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            mon_g = {digit_en, frame_done, blank, tens_bcd, units_bcd, upd_ready};
            vectors++;
            if (mon_g !== mon_e) begin
                miscompares++;
                $display("FAIL scan cycle %0d: got de=%b fd=%b blank=%b tens=%0d units=%0d ready=%b, expected de=%b fd=%b blank=%b tens=%0d units=%0d ready=%b",
                         cyc, mon_g.de, mon_g.fd, mon_g.bl, mon_g.t, mon_g.u, mon_g.rdy,
                         mon_e.de, mon_e.fd, mon_e.bl, mon_e.t, mon_e.u, mon_e.rdy);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dv;
        int br;
        int guard;
        rst       = 1'b0;
        div_i     = 16'd0;
        bright_i  = 4'd0;
        upd_valid = 1'b0;
        upd_tens  = 4'd0;
        upd_units = 4'd0;

        // Reset release with dwell 10, near-full brightness
        dv = 9; br = 15;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 4'd0, 4'd0, dv, br);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 4'd0, 4'd0, dv, br);
        step(1'b1, 1'b1, 4'd4, 4'd2, dv, br);
        for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 4'd0, 4'd0, dv, br);
        // Update held against a busy shadow buffer
        step(1'b1, 1'b1, 4'd1, 4'd3, dv, br);
        for (int i = 0; i < 60; i++) step(1'b1, 1'b1, 4'd7, 4'd5, dv, br);

        // Long dwell at quarter brightness
        dv = 31; br = 4;
        for (int i = 0; i < 160; i++) step(1'b1, 1'b0, 4'd0, 4'd0, dv, br);

        // Reset in SHOW with an update still pending
        dv = 20; br = 9;
        guard = 0;
        while (!m_pending && guard < 200) begin
            step(1'b1, 1'b1, 4'd9, 4'd8, dv, br);
            guard++;
        end
        guard = 0;
        while (!(m_pending && m_pos > BLANK_CYC) && guard < 200) begin
            step(1'b1, 1'b0, 4'd0, 4'd0, dv, br);
            guard++;
        end
        step(1'b0, 1'b0, 4'd0, 4'd0, dv, br);
        step(1'b0, 1'b0, 4'd0, 4'd0, dv, br);
        for (int i = 0; i < 100; i++) step(1'b1, 1'b0, 4'd0, 4'd0, dv, br);

        // Randomized traffic, including div 0, bright 0 and bright 15
        dv = 0; br = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) dv = $urandom_range(0, 12);
            if ($urandom_range(0, 39) == 0) br = $urandom_range(0, 15);
            step(($urandom_range(0, 399) != 0),
                 ($urandom_range(0, 99) < 15),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), dv, br);
        end

        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
